lru_age_tracker: RTL
====================

Name: lru_age_tracker

Overview:
Per-way age bookkeeping for the fully associative cache. It records hits, fills, invalidates and flushes, and maintains one saturating age counter and one valid bit per way. The flattened age vector feeds the existing max-value/index compare tree, which selects the victim: the oldest way, or any invalid way. The block also reports occupancy and the lowest-indexed free way for fills.

Parameters:
NUM_WAYS, 8, number of cache ways (>=2)
AGE_WIDTH, 4, bits per age counter (>=2)
WAY_WIDTH, $clog2(NUM_WAYS), way index width (derived; do not override)

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous active-high reset
touch_v_i  input  1  access this cycle (hit or fill)
touch_way_i  input  WAY_WIDTH  way accessed
inval_v_i  input  1  invalidate one way this cycle
inval_way_i  input  WAY_WIDTH  way to invalidate
flush_i  input  1  invalidate all ways
age_o  output  NUM_WAYS*AGE_WIDTH  ages, way i at bits [i*AGE_WIDTH +: AGE_WIDTH]
valid_o  output  NUM_WAYS  per-way valid
occupancy_o  output  WAY_WIDTH+1  count of valid ways
has_free_o  output  1  at least one way invalid
free_way_o  output  WAY_WIDTH  lowest-index invalid way; 0 when has_free_o=0

Behaviour:
- One clock; reset is synchronous and active-high.
- Constants: AGE_MAX = 2^AGE_WIDTH-1 marks an invalid way. AGE_SAT = AGE_MAX-1 is the ceiling for valid ways.
  - Invalid ways therefore always strictly out-age valid ways in a ">" compare tree.
- Reset (reset_i=1 at a clock edge):
  - valid_o=0, every age=AGE_MAX, occupancy_o=0.
  - has_free_o=1, free_way_o=0 (visible the next cycle).
- All state updates are registered; effects appear one cycle after the inputs. age_o, valid_o and occupancy_o are register outputs.
- has_free_o and free_way_o are combinational from valid_o (priority encoder, lowest index wins).
- Priority per edge: reset_i > flush_i > per-way rules below.
- flush_i=1: same end state as reset. touch_v_i and inval_v_i are ignored that cycle.
- Per way i, when there is no reset or flush:
  - inval_v_i && inval_way_i==i: valid[i]<=0, age[i]<=AGE_MAX. This takes precedence over a touch of the same way.
  - else touch_v_i && touch_way_i==i: valid[i]<=1, age[i]<=0.
  - else touch_v_i && valid[i]: age[i]<=min(age[i]+1, AGE_SAT). Saturating; never wraps.
  - else: hold.
- Aging is access-driven only. Idle cycles do not change ages. Invalid ways keep AGE_MAX.
- A touch and an invalidate of different ways in the same cycle:
  - Both take effect.
  - Other valid ways age by one.
  - The invalidated way does not age (it becomes AGE_MAX).
- A touch of an already valid way resets it to 0; occupancy_o is unchanged.
- occupancy_o is a registered counter, updated by the net change per cycle:
  - +1 for a touch of an invalid way.
  - -1 for an invalidate of a valid way.
  - Both may happen in one cycle (net 0).
  - Invalidating an already invalid way does not change it.
  - Must always equal popcount(valid_o); verify with an assertion.
- Way indices >= NUM_WAYS (non-power-of-2 NUM_WAYS) are ignored. A touch with an out-of-range index causes no aging at all.
- No handshake backpressure: the block accepts one touch plus one invalidate every cycle.

Test Plan:
- Reset, then idle 3 cycles:
  - valid_o=0, all ages=15 (AGE_WIDTH=4), occupancy_o=0.
  - has_free_o=1, free_way_o=0.
- Touch ways 0,1,2 on consecutive cycles:
  - After the third edge, ages way0=2, way1=1, way2=0, ways3..7=15.
  - occupancy_o=3, free_way_o=3.
- Touch way 0 twenty times, then touch way 1 once:
  - way1=0, way0=1.
  - Repeat touching way 1 for 20 cycles: way0 saturates at 14, never 15 or 0.
- Fill all 8 ways, then assert inval_v_i on way 5 together with a touch of way 2:
  - valid[5]=0, age[5]=15, age[2]=0.
  - Other ways incremented by one; occupancy_o=7, free_way_o=5.
- Touch and invalidate way 4 in the same cycle:
  - way4 invalid, age=15, occupancy_o unchanged if it was already invalid.
- Mid-sequence flush_i asserted together with touch_v_i:
  - Next cycle, state equals the reset state.
  - Same check with reset_i asserted during back-to-back touches.

Source files
------------

// File: rtl/lru_age_tracker.sv
// Per-way age and valid bookkeeping for a fully associative cache.
// Invalid ways sit at AGE_MAX. Valid ways saturate at AGE_MAX-1, so a ">" compare
// tree on age_o always prefers an invalid way over any valid way.
module lru_age_tracker #(
  parameter  int NUM_WAYS  = 8,
  parameter  int AGE_WIDTH = 4,
  localparam int WAY_WIDTH = $clog2(NUM_WAYS)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          touch_v_i,
  input  logic [WAY_WIDTH-1:0]          touch_way_i,
  input  logic                          inval_v_i,
  input  logic [WAY_WIDTH-1:0]          inval_way_i,
  input  logic                          flush_i,
  output logic [NUM_WAYS*AGE_WIDTH-1:0] age_o,
  output logic [NUM_WAYS-1:0]           valid_o,
  output logic [WAY_WIDTH:0]            occupancy_o,
  output logic                          has_free_o,
  output logic [WAY_WIDTH-1:0]          free_way_o
);

  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;
  localparam logic [AGE_WIDTH-1:0] AGE_SAT = AGE_MAX - AGE_WIDTH'(1);

  logic [NUM_WAYS-1:0][AGE_WIDTH-1:0] age_q, age_d;
  logic [NUM_WAYS-1:0]                valid_q, valid_d;
  logic [WAY_WIDTH:0]                 occ_q, occ_d;
  logic                               touch_ok, inval_ok;
  logic                               occ_inc, occ_dec;
  logic [NUM_WAYS-1:0]                touch_sel, inval_sel;

  // An out-of-range touch is dropped entirely, including the aging of other ways.
  assign touch_ok = touch_v_i && ({1'b0, touch_way_i} < (WAY_WIDTH+1)'(NUM_WAYS));
  assign inval_ok = inval_v_i && ({1'b0, inval_way_i} < (WAY_WIDTH+1)'(NUM_WAYS));

  // Per-way next state: invalidate beats touch; a touch ages every other valid way.
  always_comb begin
    age_d     = age_q;
    valid_d   = valid_q;
    occ_inc   = 1'b0;
    occ_dec   = 1'b0;
    touch_sel = '0;
    inval_sel = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      touch_sel[i] = touch_ok && (touch_way_i == WAY_WIDTH'(i));
      inval_sel[i] = inval_ok && (inval_way_i == WAY_WIDTH'(i));
      if (inval_sel[i]) begin
        valid_d[i] = 1'b0;
        age_d[i]   = AGE_MAX;
        if (valid_q[i]) occ_dec = 1'b1;
      end else if (touch_sel[i]) begin
        valid_d[i] = 1'b1;
        age_d[i]   = '0;
        if (!valid_q[i]) occ_inc = 1'b1;
      end else if (touch_ok && valid_q[i]) begin
        if (age_q[i] < AGE_SAT) age_d[i] = age_q[i] + AGE_WIDTH'(1);
      end
    end
    occ_d = occ_q + (WAY_WIDTH+1)'(occ_inc) - (WAY_WIDTH+1)'(occ_dec);
  end

  // State registers; reset and flush both return every way to invalid.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < NUM_WAYS; i++) age_q[i] <= AGE_MAX;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      age_q   <= age_d;
    end
  end

  // Lowest-index invalid way; scanning high to low lets the lowest index win.
  always_comb begin
    has_free_o = 1'b0;
    free_way_o = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_free_o = 1'b1;
        free_way_o = WAY_WIDTH'(i);
      end
    end
  end

  assign age_o       = age_q;
  assign valid_o     = valid_q;
  assign occupancy_o = occ_q;

  // The incremental occupancy counter must never drift from the valid bits.
  occ_matches_valid : assert property (@(posedge clk_i) disable iff (reset_i)
    occ_q == (WAY_WIDTH+1)'($countones(valid_q)));

endmodule
